uart9_write_scheduler: RTL
==========================

// Module: uart9_write_scheduler
// PURPOSE
//  Round-robin scheduler that shares one 9-bit UART frame channel among NUM_REQ write requesters.
//  Each request (addr, data) becomes an address frame {1,addr} and then a data frame {0,data}.
//  The frames drive the 9-bit slave memory protocol: bit8=1 loads the write pointer, bit8=0 writes data.
//  Sits between the on-chip requesters and the 9-bit UART transmitter/serializer.
// PARAMETERS
//  NUM_REQ    4  number of requesters (>=2)
//  MEM_DEPTH  8  slave memory depth; an address >= MEM_DEPTH is rejected
// PORTS
//  clk         in   1          system clock; all logic on posedge
//  rst         in   1          synchronous, active-high reset
//  req         in   NUM_REQ    per-requester request; held until matching grant
//  req_addr    in   8*NUM_REQ  packed addresses; requester i uses [8i+7:8i]
//  req_data    in   8*NUM_REQ  packed data bytes; requester i uses [8i+7:8i]
//  grant       out  NUM_REQ    one-hot, 1-cycle pulse: request i consumed
//  addr_err    out  1          1-cycle pulse: granted request had an out-of-range address
//  frame_out   out  9          frame to the transmitter; bit8 = address flag
//  frame_valid out  1          frame_out is valid
//  frame_ready in   1          transmitter accepts frame when frame_valid && frame_ready
//  busy        out  1          high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; rr_ptr=0; address cache invalid. rst has priority over all events.
//  FSM states: IDLE, SEND_ADDR, SEND_DATA. All outputs are registered.
//  IDLE:
//   - Search req starting at rr_ptr, wrapping modulo NUM_REQ. A requester whose grant is high this cycle is masked.
//   - The first hit is the winner idx. Latch its addr/data.
//   - If addr >= MEM_DEPTH: next cycle grant[idx]=1 and addr_err=1. rr_ptr=idx+1 mod NUM_REQ. Stay IDLE. No frame is sent.
//   - Otherwise go to SEND_ADDR. Arbitration latency is 1 cycle.
//  SEND_ADDR:
//   - frame_valid=1, frame_out={1'b1,addr}.
//   - Both are held stable until the handshake, then go to SEND_DATA.
//  SEND_DATA:
//   - frame_valid=1, frame_out={1'b0,data}, held until the handshake.
//   - On the handshake: next cycle grant[idx]=1, frame_valid=0, rr_ptr=idx+1 mod NUM_REQ, state=IDLE.
//  frame_valid never deasserts without a handshake (except on rst). frame_out changes only after a handshake.
//  req/addr/data are sampled only in IDLE. Deasserting req mid-transaction is ignored; the transaction completes.
//  With frame_ready tied high: addr frame at T+1, data frame at T+2, grant at T+3.
//   That is 3 cycles per write, back-to-back.
//  rst mid-transaction aborts immediately: frame_valid=0 and grant=0 next cycle. The held req is re-served from IDLE.
//  Simultaneous events:
//   - new req arriving in the grant cycle is eligible;
//   - all requesters active -> strict rotation with no starvation.
// CONFIGURATION
//  Macro ADDR_CACHE_EN:
//   Defined:
//    - Keep last_addr/last_valid, updated on every address-frame handshake.
//    - If the winner addr == last_addr and last_valid, skip SEND_ADDR and go IDLE->SEND_DATA (2 cycles per write).
//    - The cache is invalidated by rst only.
//   Undefined:
//    - An address frame is always sent before each data frame. No cache registers exist.
// TESTING
//  1. req[0], addr=3, data=A5, ready=1 -> frame_out 0x103, then 0x0A5 on consecutive cycles; grant=0001 one cycle later.
//  2. Two contention cases:
//     - req[0] and req[2] together after reset -> service order 0 then 2.
//     - then all four req held -> order 3,0,1,2,3.
//  3. frame_ready=0 for 5 cycles during the address frame -> frame_out holds 0x103 with valid=1, then data 0x0A5 follows.
//  4. req[1], addr=9 (MEM_DEPTH=8) -> grant=0010 and addr_err=1 for one cycle; frame_valid stays 0.
//  5. rst=1 during SEND_DATA with req[2] held -> next cycle valid=0, busy=0.
//     After release, req[2] is re-sent starting with its address frame.
//  6. Two writes to addr=5 (data 11, 22):
//     - with ADDR_CACHE_EN -> 0x105, 0x011, 0x022;
//     - without -> 0x105, 0x011, 0x105, 0x022.

Source files
------------

// File: rtl/uart9_write_scheduler.sv
// uart9_write_scheduler: round-robin scheduler turning write requests into 9-bit UART address/data frames.
// Optional ADDR_CACHE_EN skips the address frame when the target matches the last address sent.
module uart9_write_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int MEM_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 addr_err,
    output logic [8:0]           frame_out,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 busy
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SEND_ADDR, SEND_DATA} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               addr_err_q, addr_err_d;
    logic [8:0]         frame_out_q, frame_out_d;
    logic               frame_valid_q, frame_valid_d;
    logic               busy_q, busy_d;
    logic               found, cache_hit, addr_bad;
    logic [IW-1:0]      win, j;
    logic [7:0]         win_addr, win_data;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NUM_REQ);
    endfunction

    // A requester being granted this cycle still holds req, so it is masked out
    always_comb begin
        found = |(req & ~grant_q);
        win   = '0;
        j     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = wrap(int'(rr_ptr_q) + k);
            if (req[j] && !grant_q[j]) win = j;
        end
    end

    assign win_addr = req_addr[8*win +: 8];
    assign win_data = req_data[8*win +: 8];
    assign addr_bad = int'(win_addr) >= MEM_DEPTH;

`ifdef ADDR_CACHE_EN
    logic [7:0] last_addr_q, last_addr_d;
    logic       last_valid_q, last_valid_d;
    logic       addr_hs;
    always_comb begin
        addr_hs      = state_q == SEND_ADDR && frame_ready;
        last_addr_d  = addr_hs ? frame_out_q[7:0] : last_addr_q;
        last_valid_d = last_valid_q | addr_hs;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_addr_q  <= last_addr_d;
            last_valid_q <= last_valid_d;
        end
    end
    assign cache_hit = last_valid_q && last_addr_q == win_addr;
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        idx_d         = idx_q;
        data_d        = data_q;
        grant_d       = '0;
        addr_err_d    = 1'b0;
        frame_out_d   = frame_out_q;
        frame_valid_d = frame_valid_q;
        case (state_q)
            IDLE: if (found) begin
                idx_d  = win;
                data_d = win_data;
                if (addr_bad) begin
                    grant_d[win] = 1'b1;
                    addr_err_d   = 1'b1;
                    rr_ptr_d     = wrap(int'(win) + 1);
                end else begin
                    state_d       = cache_hit ? SEND_DATA : SEND_ADDR;
                    frame_valid_d = 1'b1;
                    frame_out_d   = cache_hit ? {1'b0, win_data} : {1'b1, win_addr};
                end
            end
            SEND_ADDR: if (frame_ready) begin
                state_d     = SEND_DATA;
                frame_out_d = {1'b0, data_q};
            end
            SEND_DATA: if (frame_ready) begin
                state_d        = IDLE;
                grant_d[idx_q] = 1'b1;
                frame_valid_d  = 1'b0;
                rr_ptr_d       = wrap(int'(idx_q) + 1);
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            idx_q         <= '0;
            data_q        <= '0;
            grant_q       <= '0;
            addr_err_q    <= 1'b0;
            frame_out_q   <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            grant_q       <= grant_d;
            addr_err_q    <= addr_err_d;
            frame_out_q   <= frame_out_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign grant       = grant_q;
    assign addr_err    = addr_err_q;
    assign frame_out   = frame_out_q;
    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;
endmodule
